// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
//
// Steps an external combinational full-adder cell (a, b, c -> x = sum, y = carry)
// across WIDTH-bit operands, one bit per clock, LSB first. The carry is held in a
// register between cycles and the sum bits are shifted in from the top.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             operation request, accepted in IDLE or DONE
//   op_a, op_b, cin   operands and carry-in, captured when start is accepted
//   fa_a, fa_b, fa_c  drive the cell inputs; zero outside RUN
//   fa_x, fa_y        cell sum and carry outputs
//   busy              high for the WIDTH cycles of RUN
//   done              one-cycle pulse; sum/cout carry the new result
//   sum, cout         registered result, held until the next operation completes

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_x,
    input  logic             fa_y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        load     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_c     = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = start;
            end
            StRun: begin
                busy = 1'b1;
                // Cell inputs come straight from registers, so they are stable all cycle.
                fa_a = a_sh_q[0];
                fa_b = b_sh_q[0];
                fa_c = carry_q;

                sum_sh_d            = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1]   = fa_x;
                carry_d             = fa_y;
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                cnt_d               = cnt_q + CntOne;

                if (cnt_q == CntLast) begin
                    // Publish only on the final bit so no partial result is ever visible.
                    sum_d   = sum_sh_d;
                    cout_d  = fa_y;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                load    = start;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accepting a new operation leaves sum/cout untouched until it completes.
        if (load) begin
            a_sh_d   = op_a;
            b_sh_d   = op_b;
            carry_d  = cin;
            cnt_d    = '0;
            sum_sh_d = '0;
            state_d  = StRun;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: a WIDTH=8 instance for the main scenarios and a
// WIDTH=1 instance for the exhaustive single-bit case, each with a behavioural cell.

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       fa_a8, fa_b8, fa_c8, fa_x8, fa_y8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    assign fa_x8 = fa_a8 ^ fa_b8 ^ fa_c8;
    assign fa_y8 = (fa_a8 & fa_b8) | (fa_a8 & fa_c8) | (fa_b8 & fa_c8);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .op_a (a8),
        .op_b (b8),
        .cin  (cin8),
        .fa_a (fa_a8),
        .fa_b (fa_b8),
        .fa_c (fa_c8),
        .fa_x (fa_x8),
        .fa_y (fa_y8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .cout (cout8)
    );

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       fa_a1, fa_b1, fa_c1, fa_x1, fa_y1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    assign fa_x1 = fa_a1 ^ fa_b1 ^ fa_c1;
    assign fa_y1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .op_a (a1),
        .op_b (b1),
        .cin  (cin1),
        .fa_a (fa_a1),
        .fa_b (fa_b1),
        .fa_c (fa_c1),
        .fa_x (fa_x1),
        .fa_y (fa_y1),
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
        .cout (cout1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called one step after the acceptance edge (first RUN cycle). Returns the number
    // of edges until done, busy cycles seen, and whether sum held prev throughout.
    task automatic wait_done(input logic [7:0] prev, output int cyc, output int bcnt,
                             output logic held);
        cyc  = 0;
        bcnt = 0;
        held = 1'b1;
        while (!done8 && cyc < 40) begin
            if (busy8) bcnt++;
            if (sum8 !== prev) held = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Runs one WIDTH=8 operation; returns positioned in the DONE cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input string nm);
        logic [7:0] prev;
        int         cyc, bcnt;
        logic       held;
        prev = sum8;
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = ci;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk({nm, " fa_a"}, 32'(fa_a8), 32'(a[0]));
        chk({nm, " fa_b"}, 32'(fa_b8), 32'(b[0]));
        chk({nm, " fa_c"}, 32'(fa_c8), 32'(ci));
        wait_done(prev, cyc, bcnt, held);
        chk({nm, " latency"}, 32'(cyc), 32'd8);
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'd8);
        chk({nm, " sum_held"}, 32'(held), 32'd1);
        chk({nm, " sum"}, 32'(sum8), 32'(es));
        chk({nm, " cout"}, 32'(cout8), 32'(ec));
        chk({nm, " busy_in_done"}, 32'(busy8), 32'd0);
        chk({nm, " fa_in_done"}, 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        string      name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, bcnt, ndone;
        logic       held;
        logic [2:0] combo;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple"};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "overflow"};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only"};
        vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "alt_bits"};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "msb_set"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        chk("rst sum", 32'(sum8), 32'd0);
        chk("rst cout", 32'(cout8), 32'd0);
        chk("rst fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle no start", 32'({busy8, done8}), 32'd0);

        // Table-driven adds
        for (int i = 0; i < 6; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].name);
        end
        @(posedge clk);
        #1;
        chk("done one pulse", 32'(done8), 32'd0);

        // Back-to-back: new start issued in the DONE cycle of 0x01+0x01
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "b2b_first");
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h80;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b busy after done", 32'(busy8), 32'd1);
        wait_done(8'h02, cyc, bcnt, held);
        chk("b2b spacing", 32'(cyc + 1), 32'd9);
        chk("b2b sum_held", 32'(held), 32'd1);
        chk("b2b sum", 32'(sum8), 32'h00);
        chk("b2b cout", 32'(cout8), 32'd1);

        // Busy protection: start stays high and operands churn during RUN
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h12;
        b8     = 8'h34;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        start8 = 1'b0;
        chk("prot latency", 32'(cyc), 32'd8);
        chk("prot sum", 32'(sum8), 32'h46);
        chk("prot cout", 32'(cout8), 32'd0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) ndone++;
        end
        chk("prot no extra op", 32'(ndone), 32'd0);

        // Reset in the middle of RUN (cycle 4), with sum=0x46 still published
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h5A;
        b8     = 8'h3C;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre-rst fa_a", 32'(fa_a8), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-rst busy", 32'(busy8), 32'd0);
        chk("mid-rst done", 32'(done8), 32'd0);
        chk("mid-rst sum", 32'(sum8), 32'd0);
        chk("mid-rst cout", 32'(cout8), 32'd0);
        chk("mid-rst fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) ndone++;
        end
        chk("post-rst idle", 32'(ndone), 32'd0);
        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "post_rst");

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            @(negedge clk);
            start1 = 1'b1;
            a1     = combo[2];
            b1     = combo[1];
            cin1   = combo[0];
            @(posedge clk);
            #1;
            start1 = 1'b0;
            chk($sformatf("w1 busy %0d", i), 32'({busy1, done1}), 32'b10);
            @(posedge clk);
            #1;
            chk($sformatf("w1 done %0d", i), 32'({busy1, done1}), 32'b01);
            chk($sformatf("w1 result %0d", i), 32'({cout1, sum1}),
                32'(combo[2]) + 32'(combo[1]) + 32'(combo[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
